dsp_sensor_cal: RTL and testbench

Multi-channel calibration and readout controller for the DSP timing sensors. It sweeps each channel's clock-path IDELAY tap count until the sensor's DSP output popcount crosses a target, then locks that tap. After all channels are locked it streams per-channel popcounts on a valid/ready interface. It sits between the N_CH sensor instances (driving their taps_clk, consuming their P) and the capture/transfer logic.

---
 rtl/dsp_sensor_pkg.sv | 25 ++
 rtl/sensor_popcount.sv | 32 +++
 rtl/dsp_sensor_cal.sv | 181 ++++++++++++++++++
 tb/tb_dsp_sensor_cal.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_sensor_pkg.sv
// Shared types and default widths for the DSP timing-sensor calibration controller.
// Imported by the top level and by the popcount sub-module.
package dsp_sensor_pkg;

   localparam int DEF_N_CH     = 4;
   localparam int DEF_P_W      = 48;
   localparam int DEF_TAP_W    = 9;
   localparam int DEF_SETTLE   = 16;
   localparam int DEF_AVG_LOG2 = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_ACCUM,
      ST_EVAL,
      ST_NEXT_CH,
      ST_RUN
   } cal_state_t;

   // Bits needed to hold a popcount of p_w bits (0..p_w inclusive).
   function automatic int hw_width(input int p_w);
      return $clog2(p_w + 1);
   endfunction

endpackage

// File: rtl/sensor_popcount.sv
// Registered popcount of one sensor channel's raw output word.
// Forms stage 2 of the always-running input pipeline.
module sensor_popcount
   import dsp_sensor_pkg::*;
#(
   parameter int P_W = DEF_P_W,
   localparam int HW_W = hw_width(P_W)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [P_W-1:0]  d,
   output logic [HW_W-1:0] pc
);

   logic [HW_W-1:0] sum;

   always_comb begin
      sum = '0;
      for (int i = 0; i < P_W; i++) begin
         sum = sum + HW_W'(d[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc <= '0;
      end else begin
         pc <= sum;
      end
   end

endmodule

// File: rtl/dsp_sensor_cal.sv
// Sweeps each channel's clock-path IDELAY tap until the averaged sensor popcount
// reaches TARGET, locks it, then streams per-channel popcounts on valid/ready.
module dsp_sensor_cal
   import dsp_sensor_pkg::*;
#(
   parameter int N_CH     = DEF_N_CH,
   parameter int P_W      = DEF_P_W,
   parameter int TAP_W    = DEF_TAP_W,
   parameter int SETTLE   = DEF_SETTLE,
   parameter int AVG_LOG2 = DEF_AVG_LOG2,
   parameter int TARGET   = P_W / 2,
   localparam int HW_W    = hw_width(P_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [N_CH*P_W-1:0]   sensor_p,
   input  logic [TAP_W-1:0]      taps_a_in,
   output logic [N_CH*TAP_W-1:0] taps_clk,
   output logic [N_CH*TAP_W-1:0] taps_a,
   output logic                  busy,
   output logic                  done,
   output logic [N_CH-1:0]       cal_fail,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [N_CH*HW_W-1:0]  m_data,
   output logic [15:0]           drop_cnt
);

   localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int AVG_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int ACC_W    = HW_W + AVG_LOG2;
   localparam logic [ACC_W:0] THRESH = (ACC_W + 1)'(TARGET << AVG_LOG2);

   cal_state_t state, next_state;

   logic [N_CH*P_W-1:0]  stage1;
   logic [HW_W-1:0]      pc [N_CH];
   logic [N_CH*HW_W-1:0] pc_flat;
   logic [TAP_W-1:0]     tap_q [N_CH];
   logic [CH_W-1:0]      ch;
   logic [SETTLE_W-1:0]  settle_cnt;
   logic [AVG_W-1:0]     accum_cnt;
   logic [ACC_W-1:0]     acc;

   logic restart, tap_inc, set_fail, ch_inc, acc_clr, go_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage1 <= '0;
      end else begin
         stage1 <= sensor_p;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      sensor_popcount #(.P_W(P_W)) u_popcount (
         .clk (clk),
         .rst (rst),
         .d   (stage1[c*P_W +: P_W]),
         .pc  (pc[c])
      );
      assign pc_flat[c*HW_W +: HW_W]    = pc[c];
      assign taps_clk[c*TAP_W +: TAP_W] = tap_q[c];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      restart    = 1'b0;
      tap_inc    = 1'b0;
      set_fail   = 1'b0;
      ch_inc     = 1'b0;
      acc_clr    = 1'b0;
      go_done    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               next_state = ST_SETTLE;
               restart    = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (settle_cnt == SETTLE_W'(SETTLE - 1)) next_state = ST_ACCUM;
         end
         ST_ACCUM: begin
            if (accum_cnt == AVG_W'((1 << AVG_LOG2) - 1)) next_state = ST_EVAL;
         end
         ST_EVAL: begin
            if ({1'b0, acc} >= THRESH) begin
               next_state = ST_NEXT_CH;
            end else if (tap_q[ch] == '1) begin
               set_fail   = 1'b1;
               next_state = ST_NEXT_CH;
            end else begin
               tap_inc    = 1'b1;
               acc_clr    = 1'b1;
               next_state = ST_SETTLE;
            end
         end
         ST_NEXT_CH: begin
            if (ch == CH_W'(N_CH - 1)) begin
               go_done    = 1'b1;
               next_state = ST_RUN;
            end else begin
               ch_inc     = 1'b1;
               acc_clr    = 1'b1;
               next_state = ST_SETTLE;
            end
         end
         ST_RUN: begin
            if (start) begin
               next_state = ST_SETTLE;
               restart    = 1'b1;
            end
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Sweep datapath: only the channel under calibration ever has its tap moved.
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         ch       <= '0;
         acc      <= '0;
         cal_fail <= '0;
         for (int c = 0; c < N_CH; c++) tap_q[c] <= '0;
      end else begin
         if (acc_clr) begin
            acc <= '0;
         end else if (state == ST_ACCUM) begin
            acc <= acc + ACC_W'(pc[ch]);
         end
         if (tap_inc)  tap_q[ch]    <= tap_q[ch] + 1'b1;
         if (set_fail) cal_fail[ch] <= 1'b1;
         if (ch_inc)   ch           <= ch + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         settle_cnt <= '0;
         accum_cnt  <= '0;
      end else begin
         settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 1'b1 : '0;
         accum_cnt  <= (state == ST_ACCUM) ? accum_cnt + 1'b1 : '0;
      end
   end

   // Status and stream outputs; a restart from RUN drops m_valid on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         m_valid  <= 1'b0;
         m_data   <= '0;
         drop_cnt <= '0;
         taps_a   <= '0;
      end else begin
         busy    <= (next_state != ST_IDLE) && (next_state != ST_RUN);
         done    <= go_done;
         m_valid <= (state == ST_RUN) && (next_state == ST_RUN);
         taps_a  <= {N_CH{taps_a_in}};
         if (state == ST_RUN && (!m_valid || m_ready)) m_data <= pc_flat;
         if (restart) begin
            drop_cnt <= '0;
         end else if (state == ST_RUN && m_valid && !m_ready && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_dsp_sensor_cal.sv
// Directed bench for dsp_sensor_cal: tap-dependent sensor model for calibration,
// hand-computed popcount vectors checked through a stream scoreboard.
module tb_dsp_sensor_cal;

   logic         clk;
   logic         rst;
   logic         start;
   logic [191:0] sensor_p;
   logic [8:0]   taps_a_in;
   logic [35:0]  taps_clk;
   logic [35:0]  taps_a;
   logic         busy;
   logic         done;
   logic [3:0]   cal_fail;
   logic         m_valid;
   logic         m_ready;
   logic [23:0]  m_data;
   logic [15:0]  drop_cnt;

   logic         vec_mode;
   logic [191:0] vec;
   logic [3:0]   hold_ch;
   logic [23:0]  sb [$];
   int           vectors;
   int           miscompares;

   localparam logic [191:0] S0  = {48'h800000000000, 48'h000000000001, 48'hFFFFFFFFFFFF, 48'h000000000000};
   localparam logic [23:0]  ES0 = {6'd1, 6'd1, 6'd48, 6'd0};
   localparam logic [191:0] W0  = {48'h123456789ABC, 48'hAAAAAAAAAAAA, 48'h0000000000FF, 48'hF0F0F0F0F0F0};
   localparam logic [23:0]  EW0 = {6'd22, 6'd24, 6'd8, 6'd24};
   localparam logic [191:0] W1  = {48'h000000000000, 48'h000FFF000FFF, 48'h7FFFFFFFFFFF, 48'hFFFFFFFFFFFE};
   localparam logic [23:0]  EW1 = {6'd0, 6'd24, 6'd47, 6'd47};
   localparam logic [191:0] W2  = {48'hFFFFFFFFFFFF, 48'hFFFF00000000, 48'h800000000001, 48'h000000000005};
   localparam logic [23:0]  EW2 = {6'd48, 6'd16, 6'd2, 6'd2};
   localparam logic [23:0]  ELOCK = {6'd24, 6'd24, 6'd24, 6'd24};

   dsp_sensor_cal dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sensor_p  (sensor_p),
      .taps_a_in (taps_a_in),
      .taps_clk  (taps_clk),
      .taps_a    (taps_a),
      .busy      (busy),
      .done      (done),
      .cal_fail  (cal_fail),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [47:0] ones(input int k);
      logic [63:0] m;
      m = (k <= 0) ? 64'd0 : (~64'd0 >> (64 - k));
      return m[47:0];
   endfunction

   // Channel c needs 8*c more taps than channel 0 to reach the same popcount.
   function automatic logic [47:0] model_ch(input int c, input logic [8:0] tap, input logic hold);
      int k;
      if (hold || int'(tap) < 8 * c) k = 0;
      else k = (int'(tap) - 8 * c) / 4;
      if (k > 48) k = 48;
      return ones(k);
   endfunction

   always_comb begin
      sensor_p = '0;
      if (vec_mode) begin
         sensor_p = vec;
      end else begin
         for (int c = 0; c < 4; c++) begin
            sensor_p[c*48 +: 48] = model_ch(c, taps_clk[c*9 +: 9], hold_ch[c]);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic [191:0] v, input logic [23:0] e);
      vec = v;
      sb.push_back(e);
   endtask

   task automatic pulseStart();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic waitDone(input string name, input int exp_cycles, input int pulse_at);
      int  cycles;
      bit  seen;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 40000) begin
         @(posedge clk); #1;
         cycles++;
         start = (cycles == pulse_at);
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL %s: done never seen within %0d cycles", name, cycles);
      end else begin
         checkOutput({name, " done cycle"}, 64'(cycles), 64'(exp_cycles));
         checkOutput({name, " busy at done"}, 64'(busy), 64'd0);
         checkOutput({name, " m_valid at done"}, 64'(m_valid), 64'd0);
      end
   endtask

   // Stream monitor: every accepted beat must match the oldest expected entry.
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL stream: unexpected beat 0x%0h with empty scoreboard", m_data);
         end else begin
            checkOutput("stream beat", 64'(m_data), 64'(sb.pop_front()));
         end
      end
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      start       = 1'b0;
      m_ready     = 1'b0;
      taps_a_in   = '0;
      vec_mode    = 1'b0;
      vec         = '0;
      hold_ch     = '0;

      repeat (5) @(posedge clk);
      #1;
      checkOutput("reset taps_clk", 64'(taps_clk), 64'd0);
      checkOutput("reset taps_a", 64'(taps_a), 64'd0);
      checkOutput("reset busy", 64'(busy), 64'd0);
      checkOutput("reset done", 64'(done), 64'd0);
      checkOutput("reset cal_fail", 64'(cal_fail), 64'd0);
      checkOutput("reset m_valid", 64'(m_valid), 64'd0);
      checkOutput("reset m_data", 64'(m_data), 64'd0);
      checkOutput("reset drop_cnt", 64'(drop_cnt), 64'd0);

      rst       = 1'b0;
      taps_a_in = 9'h1A5;
      repeat (10) @(posedge clk);
      #1;
      checkOutput("idle m_valid", 64'(m_valid), 64'd0);
      checkOutput("idle busy", 64'(busy), 64'd0);
      checkOutput("taps_a passthrough", 64'(taps_a), 64'({4{9'h1A5}}));

      $display("[TB] calibration with tap-offset sensor model");
      pulseStart();
      checkOutput("run1 busy after start", 64'(busy), 64'd1);
      waitDone("run1", (97 + 105 + 113 + 121) * 33 + 4, -1);
      checkOutput("run1 taps_clk", 64'(taps_clk), 64'({9'd120, 9'd112, 9'd104, 9'd96}));
      checkOutput("run1 cal_fail", 64'(cal_fail), 64'd0);

      $display("[TB] stream with backpressure");
      sb.push_back(ELOCK);
      @(posedge clk); #1;
      checkOutput("m_valid after done", 64'(m_valid), 64'd1);
      checkOutput("done one-cycle", 64'(done), 64'd0);
      vec_mode = 1'b1;
      applyStimulus(S0, ES0);
      sb.push_back(ES0);
      repeat (10) @(posedge clk);
      #1;
      checkOutput("drop_cnt after stall", 64'(drop_cnt), 64'd10);
      checkOutput("m_data held", 64'(m_data), 64'(ELOCK));
      m_ready = 1'b1;
      applyStimulus(W0, EW0);
      @(posedge clk); #1;
      applyStimulus(W1, EW1);
      @(posedge clk); #1;
      applyStimulus(W2, EW2);
      repeat (4) @(posedge clk);
      #1;
      m_ready = 1'b0;
      checkOutput("drop_cnt while ready", 64'(drop_cnt), 64'd10);
      checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);

      $display("[TB] restart from RUN, channel 2 stuck, start mid-sweep");
      vec_mode = 1'b0;
      hold_ch  = 4'b0100;
      pulseStart();
      checkOutput("restart taps_clk", 64'(taps_clk), 64'd0);
      checkOutput("restart busy", 64'(busy), 64'd1);
      checkOutput("restart m_valid", 64'(m_valid), 64'd0);
      checkOutput("restart drop_cnt", 64'(drop_cnt), 64'd0);
      waitDone("run2", (97 + 105 + 512 + 121) * 33 + 4, 500);
      checkOutput("run2 taps_clk", 64'(taps_clk), 64'({9'd120, 9'd511, 9'd104, 9'd96}));
      checkOutput("run2 cal_fail", 64'(cal_fail), 64'(4'b0100));

      $display("[TB] reset during channel 1 accumulation");
      hold_ch = '0;
      pulseStart();
      repeat (3222) @(posedge clk);
      #1;
      checkOutput("mid-ch1 busy", 64'(busy), 64'd1);
      checkOutput("mid-ch1 taps_clk", 64'(taps_clk), 64'({9'd0, 9'd0, 9'd0, 9'd96}));
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput("rst taps_clk", 64'(taps_clk), 64'd0);
      checkOutput("rst taps_a", 64'(taps_a), 64'd0);
      checkOutput("rst busy", 64'(busy), 64'd0);
      checkOutput("rst cal_fail", 64'(cal_fail), 64'd0);
      checkOutput("rst m_valid", 64'(m_valid), 64'd0);
      checkOutput("rst m_data", 64'(m_data), 64'd0);
      checkOutput("rst drop_cnt", 64'(drop_cnt), 64'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checkOutput("post-rst done", 64'(done), 64'd0);
         @(posedge clk); #1;
      end
      checkOutput("post-rst busy", 64'(busy), 64'd0);
      pulseStart();
      repeat (34) @(posedge clk);
      #1;
      checkOutput("recal busy", 64'(busy), 64'd1);
      checkOutput("recal ch0 first step", 64'(taps_clk), 64'({9'd0, 9'd0, 9'd0, 9'd1}));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
